// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: control FSM for a multi-cycle MIPS-style datapath.
//
// Instructions pass through IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The opcode is
// latched in DECODE, and the outputs are combinational decodes of the state and that latched
// opcode.
//
// Optional feature: define MULTI_CYCLE_PERF_CNT_EN to build the cycle and retired-instruction
// counters. When it is undefined, no counter flops exist and both counters read 0.
//
// Ports
//   clk_i, rst_i       clock; asynchronous active-high reset
//   run_i              level; keep issuing instructions while high
//   opcode_i           instruction[31:26], sampled in DECODE
//   zero_i             ALU zero flag, sampled in EXEC (beq)
//   mem_ready_i        memory handshake completion (FETCH/MEM only)
//   pc_write_o, ir_write_o, reg_write_o   register-update strobes
//   pc_src_o           1 = PC loads the branch target
//   reg_dst_o, alu_src_o, mem_to_reg_o    datapath mux selects
//   alu_op_o           ALU-control operation class
//   mem_req_o, mem_we_o                   memory request, write enable
//   busy_o, err_o      not-IDLE indicator; sticky illegal-opcode flag
//   state_o            current state encoding
//   retired_o, cycles_o                   performance counters (CNT_W bits)
module multi_cycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [5:0]       opcode_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ir_write_o,
  output logic             reg_write_o,
  output logic             pc_src_o,
  output logic             reg_dst_o,
  output logic             alu_src_o,
  output logic             mem_to_reg_o,
  output logic [2:0]       alu_op_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o,
  output logic [CNT_W-1:0] cycles_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5
  } state_e;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpLui  = 6'b001111;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;

  state_e     state_q;
  logic [5:0] op_q;
  logic       err_q;
  logic       op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (opcode_i)
      OpR, OpAddi, OpLui, OpLw, OpSw, OpBeq: op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      op_q    <= 6'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (run_i) begin
            state_q <= StFetch;
            err_q   <= 1'b0;
          end
        end
        StFetch: begin
          if (mem_ready_i) state_q <= StDecode;
        end
        StDecode: begin
          op_q <= opcode_i;
          if (op_legal) begin
            state_q <= StExec;
          end else begin
            state_q <= StIdle;
            err_q   <= 1'b1;
          end
        end
        StExec: begin
          case (op_q)
            OpBeq:      state_q <= run_i ? StFetch : StIdle;
            OpLw, OpSw: state_q <= StMem;
            default:    state_q <= StWb;
          endcase
        end
        StMem: begin
          if (mem_ready_i) begin
            if (op_q == OpSw) state_q <= run_i ? StFetch : StIdle;
            else              state_q <= StWb;
          end
        end
        StWb:    state_q <= run_i ? StFetch : StIdle;
        // Unused encodings recover to IDLE.
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    pc_src_o     = 1'b0;
    reg_dst_o    = 1'b0;
    alu_src_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_op_o     = 3'b000;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req_o  = 1'b1;
        ir_write_o = mem_ready_i;
        pc_write_o = mem_ready_i;
      end
      StExec: begin
        case (op_q)
          OpR:   alu_op_o = 3'b010;
          OpBeq: alu_op_o = 3'b001;
          OpLui: alu_op_o = 3'b100;
          default: alu_op_o = 3'b000;
        endcase
        alu_src_o = (op_q == OpAddi) || (op_q == OpLui) || (op_q == OpLw) || (op_q == OpSw);
        if (op_q == OpBeq && zero_i) begin
          pc_write_o = 1'b1;
          pc_src_o   = 1'b1;
        end
      end
      StMem: begin
        mem_req_o = 1'b1;
        mem_we_o  = (op_q == OpSw);
      end
      StWb: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = (op_q == OpR);
        mem_to_reg_o = (op_q == OpLw);
      end
      default: ;
    endcase
  end

  assign busy_o  = (state_q != StIdle);
  assign err_o   = err_q;
  assign state_o = state_q;

`ifdef MULTI_CYCLE_PERF_CNT_EN
  logic [CNT_W-1:0] cycles_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  // Edges that complete an instruction: WB exit, sw MEM exit, beq EXEC exit.
  assign retire = (state_q == StWb) ||
                  (state_q == StMem && mem_ready_i && op_q == OpSw) ||
                  (state_q == StExec && op_q == OpBeq);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycles_q  <= '0;
      retired_q <= '0;
    end else begin
      if (busy_o) cycles_q  <= cycles_q + CNT_W'(1);
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign cycles_o  = cycles_q;
  assign retired_o = retired_q;
`else
  assign cycles_o  = '0;
  assign retired_o = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl (CNT_W = 4 so the cycle counter wraps).
module tb_multi_cycle_ctrl;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpLui  = 6'b001111;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;

  // Output vector: {pc_write, ir_write, reg_write, pc_src, reg_dst, alu_src, mem_to_reg,
  //                 mem_req, mem_we, alu_op[2:0]}
  localparam logic [11:0] ONone   = 12'h000;
  localparam logic [11:0] OFetch  = 12'hC10;
  localparam logic [11:0] OFWait  = 12'h010;
  localparam logic [11:0] OExImm  = 12'h040;
  localparam logic [11:0] OExLui  = 12'h044;
  localparam logic [11:0] OExR    = 12'h002;
  localparam logic [11:0] OExBeqT = 12'h901;
  localparam logic [11:0] OExBeqN = 12'h001;
  localparam logic [11:0] OMemLw  = 12'h010;
  localparam logic [11:0] OMemSw  = 12'h018;
  localparam logic [11:0] OWbImm  = 12'h200;
  localparam logic [11:0] OWbR    = 12'h280;
  localparam logic [11:0] OWbLw   = 12'h220;

  logic       clk = 1'b0;
  logic       rst, run, zero, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, ir_write, reg_write, pc_src, reg_dst, alu_src, mem_to_reg;
  logic [2:0] alu_op;
  logic       mem_req, mem_we, busy, err;
  logic [2:0] state;
  logic [3:0] retired, cycles;
  logic [11:0] outs;

  int   checks = 0;
  int   failures = 0;
  int   exp_cyc = 0;
  int   exp_ret = 0;
  logic exp_err = 1'b0;

  multi_cycle_ctrl #(.CNT_W(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .run_i        (run),
    .opcode_i     (opcode),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .pc_write_o   (pc_write),
    .ir_write_o   (ir_write),
    .reg_write_o  (reg_write),
    .pc_src_o     (pc_src),
    .reg_dst_o    (reg_dst),
    .alu_src_o    (alu_src),
    .mem_to_reg_o (mem_to_reg),
    .alu_op_o     (alu_op),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .busy_o       (busy),
    .err_o        (err),
    .state_o      (state),
    .retired_o    (retired),
    .cycles_o     (cycles)
  );

  assign outs = {pc_write, ir_write, reg_write, pc_src, reg_dst, alu_src, mem_to_reg,
                 mem_req, mem_we, alu_op};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
`ifdef MULTI_CYCLE_PERF_CNT_EN
    chk({tag, ":cycles"},  {28'd0, cycles},  exp_cyc % 16);
    chk({tag, ":retired"}, {28'd0, retired}, exp_ret % 16);
`else
    chk({tag, ":cycles"},  {28'd0, cycles},  32'd0);
    chk({tag, ":retired"}, {28'd0, retired}, 32'd0);
`endif
  endtask

  // Called at a falling edge with inputs already applied: checks this cycle's state and
  // outputs, crosses the rising edge, then checks the counters.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [11:0] ov,
                     input bit retire);
    #1;
    chk({tag, ":state"}, {29'd0, state}, {29'd0, st});
    chk({tag, ":outs"},  {20'd0, outs},  {20'd0, ov});
    chk({tag, ":busy"},  {31'd0, busy},  {31'd0, (st != 3'd0)});
    chk({tag, ":err"},   {31'd0, err},   {31'd0, exp_err});
    @(posedge clk);
    if (st != 3'd0) exp_cyc++;
    if (retire) exp_ret++;
    @(negedge clk);
    chk_cnt(tag);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = OpAddi;
    @(negedge clk);
    #1;
    chk("rst:state", {29'd0, state}, 32'd0);
    chk("rst:outs",  {20'd0, outs},  32'd0);
    chk("rst:err",   {31'd0, err},   32'd0);
    chk_cnt("rst");
    rst = 1'b0;
    @(negedge clk);

    // Stay idle until run rises
    cyc("idle_hold", 3'd0, ONone, 0);
    run = 1'b1; mem_ready = 1'b1; opcode = OpAddi;
    cyc("addi_idle", 3'd0, ONone, 0);
    cyc("addi_f",    3'd1, OFetch, 0);
    cyc("addi_d",    3'd2, ONone, 0);
    cyc("addi_e",    3'd3, OExImm, 0);
    cyc("addi_wb",   3'd5, OWbImm, 1);

    // lw with a 3-cycle MEM wait; run drops mid-instruction
    opcode = OpLw;
    cyc("lw_f", 3'd1, OFetch, 0);
    cyc("lw_d", 3'd2, ONone, 0);
    cyc("lw_e", 3'd3, OExImm, 0);
    mem_ready = 1'b0;
    cyc("lw_m0", 3'd4, OMemLw, 0);
    cyc("lw_m1", 3'd4, OMemLw, 0);
    cyc("lw_m2", 3'd4, OMemLw, 0);
    mem_ready = 1'b1; run = 1'b0;
    cyc("lw_m3",   3'd4, OMemLw, 0);
    cyc("lw_wb",   3'd5, OWbLw, 1);
    cyc("lw_idle", 3'd0, ONone, 0);

    // beq taken then not taken; cycle counter wraps during this pair
    run = 1'b1; opcode = OpBeq; zero = 1'b1;
    cyc("beq_idle", 3'd0, ONone, 0);
    cyc("beq_f1",   3'd1, OFetch, 0);
    cyc("beq_d1",   3'd2, ONone, 0);
    cyc("beq_e1",   3'd3, OExBeqT, 1);
    zero = 1'b0;
    cyc("beq_f2",   3'd1, OFetch, 0);
    cyc("beq_d2",   3'd2, ONone, 0);
    run = 1'b0;
    cyc("beq_e2",   3'd3, OExBeqN, 1);
    cyc("beq_end",  3'd0, ONone, 0);

    // sw completes from MEM straight to IDLE
    run = 1'b1; opcode = OpSw;
    cyc("sw_idle", 3'd0, ONone, 0);
    cyc("sw_f",    3'd1, OFetch, 0);
    cyc("sw_d",    3'd2, ONone, 0);
    cyc("sw_e",    3'd3, OExImm, 0);
    run = 1'b0;
    cyc("sw_m",    3'd4, OMemSw, 1);
    cyc("sw_end",  3'd0, ONone, 0);

    // Illegal opcode: back to IDLE with err, cleared on FETCH entry
    run = 1'b1; opcode = 6'b111111;
    cyc("ill_idle", 3'd0, ONone, 0);
    cyc("ill_f",    3'd1, OFetch, 0);
    cyc("ill_d",    3'd2, ONone, 0);
    exp_err = 1'b1;
    cyc("ill_err",  3'd0, ONone, 0);
    exp_err = 1'b0; mem_ready = 1'b0;
    cyc("fetch_wait", 3'd1, OFWait, 0);
    mem_ready = 1'b1; opcode = OpLui;
    cyc("lui_f",  3'd1, OFetch, 0);
    cyc("lui_d",  3'd2, ONone, 0);
    cyc("lui_e",  3'd3, OExLui, 0);
    cyc("lui_wb", 3'd5, OWbImm, 1);

    // R-type
    opcode = OpR;
    cyc("r_f",  3'd1, OFetch, 0);
    cyc("r_d",  3'd2, ONone, 0);
    cyc("r_e",  3'd3, OExR, 0);
    cyc("r_wb", 3'd5, OWbR, 1);

    // Reset asserted mid-cycle during a pending MEM handshake
    opcode = OpLw;
    cyc("rl_f", 3'd1, OFetch, 0);
    cyc("rl_d", 3'd2, ONone, 0);
    cyc("rl_e", 3'd3, OExImm, 0);
    mem_ready = 1'b0;
    #1;
    chk("rl_m:state",   {29'd0, state},   32'd4);
    chk("rl_m:mem_req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mem:state", {29'd0, state}, 32'd0);
    chk("rst_mem:outs",  {20'd0, outs},  32'd0);
    chk("rst_mem:busy",  {31'd0, busy},  32'd0);
    chk("rst_mem:cycles",  {28'd0, cycles},  32'd0);
    chk("rst_mem:retired", {28'd0, retired}, 32'd0);
    exp_cyc = 0; exp_ret = 0;
    @(negedge clk);
    rst = 1'b0; run = 1'b0; mem_ready = 1'b1;
    cyc("post_rst_hold", 3'd0, ONone, 0);
    run = 1'b1; opcode = OpAddi;
    cyc("post_rst_go", 3'd0, ONone, 0);
    cyc("post_rst_f",  3'd1, OFetch, 0);
    cyc("post_rst_d",  3'd2, ONone, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of the performance counters.
REQ-002 clk_i  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 run_i  input  1  level; 1 = keep issuing instructions.
REQ-005 opcode_i  input  6  instruction[31:26], sampled in DECODE.
REQ-006 zero_i  input  1  ALU zero flag, sampled in EXEC.
REQ-007 mem_ready_i  input  1  memory handshake completion.
REQ-008 pc_write_o, ir_write_o, reg_write_o  output  1 each  register-update strobes.
REQ-009 pc_src_o  output  1  1 = PC loads branch target.
REQ-010 reg_dst_o, alu_src_o, mem_to_reg_o  output  1 each  datapath mux selects.
REQ-011 alu_op_o  output  3  ALU-control operation class.
REQ-012 mem_req_o, mem_we_o  output  1 each  memory request, write enable.
REQ-013 busy_o, err_o  output  1 each  not-IDLE indicator; sticky illegal-opcode flag.
REQ-014 state_o  output  3  current state encoding.
REQ-015 retired_o, cycles_o  output  CNT_W each  performance counters.

Function
REQ-016 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5; codes 6-7 SHALL go to IDLE on the next edge.
REQ-017 IDLE -> FETCH when run_i=1; leaving IDLE SHALL clear err_o.
REQ-018 FETCH: mem_req_o=1, mem_we_o=0 held until mem_ready_i=1; in that cycle ir_write_o=1, pc_write_o=1, pc_src_o=0; next state DECODE.
REQ-019 DECODE: one cycle; opcode_i SHALL be latched into an internal register; supported opcodes 000000 (R), 001000 (addi), 001111 (lui), 100011 (lw), 101011 (sw), 000100 (beq) -> EXEC; any other -> IDLE with err_o set.
REQ-020 EXEC: one cycle; alu_op_o = 010 (R), 000 (addi/lw/sw), 001 (beq), 100 (lui); alu_src_o=1 for addi/lui/lw/sw, else 0.
REQ-021 EXEC beq: pc_write_o=pc_src_o=1 iff zero_i=1; next FETCH if run_i=1, else IDLE.
REQ-022 EXEC R/addi/lui -> WB; lw/sw -> MEM.
REQ-023 MEM: mem_req_o=1, mem_we_o=1 for sw only, held until mem_ready_i=1; then sw -> FETCH/IDLE per run_i, lw -> WB.
REQ-024 WB: one cycle reg_write_o=1; reg_dst_o=1 for R only; mem_to_reg_o=1 for lw only; next FETCH if run_i=1, else IDLE.
REQ-025 Outputs SHALL be combinational decodes of the state and latched opcode; all unlisted outputs 0 in each state.
REQ-026 run_i falling mid-instruction SHALL NOT abort it; the instruction completes, then IDLE.
REQ-027 mem_ready_i outside FETCH/MEM SHALL be ignored; mem_req_o SHALL never drop before mem_ready_i.
REQ-028 busy_o = (state != IDLE).

Reset
REQ-029 rst_i=1 SHALL immediately force IDLE, clear latched opcode, err_o, both counters; all strobes and mem_req_o 0, regardless of any in-flight handshake.
REQ-030 After rst_i deasserts, the first possible FETCH is the first edge with run_i=1.

Configuration
REQ-031 Macro MULTI_CYCLE_PERF_CNT_EN defined: cycles_o increments every edge busy_o=1; retired_o increments on each instruction-completing edge (WB exit, sw MEM exit, beq EXEC exit); both wrap at 2^CNT_W-1 -> 0.
REQ-032 Macro undefined: no counter flops; retired_o and cycles_o tied to 0.

Verification
REQ-033 run_i=1, addi, mem_ready_i=1 always -> states 1,2,3,5,1; reg_write_o high exactly one cycle; alu_op_o=000 in EXEC.
REQ-034 lw with mem_ready_i delayed 3 cycles in MEM -> mem_req_o high 4 cycles, then WB with mem_to_reg_o=1; retired_o +1.
REQ-035 beq with zero_i=1 then zero_i=0 -> pc_src_o=pc_write_o=1 in first EXEC only; no WB visited.
REQ-036 opcode 111111 -> IDLE after DECODE, err_o=1, busy_o=0; run_i kept high -> err_o clears on FETCH entry.
REQ-037 rst_i pulse during MEM with mem_req_o=1 -> same-cycle state_o=0, mem_req_o=0, counters 0.
REQ-038 Counters preloaded near wrap (CNT_W=4, 15 cycles busy) -> cycles_o wraps 15 -> 0; with macro undefined both read 0.
